// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline hazard-control bundle: EX/ID/MEM status into the controller,
// per-stage stall/flush strobes and performance counters out of it.
interface hazard_ctrl_mc_if #(
    parameter int NRD = 2,
    parameter int AW  = 5,
    parameter int CW  = 32
);
    logic               rf_we_ex;
    logic [1:0]         rf_wd_sel_ex;
    logic [AW-1:0]      rf_wa_ex;
    logic [NRD*AW-1:0]  rf_ra_id;
    logic [NRD-1:0]     rf_re_id;
    logic [1:0]         npc_sel_ex;
    logic               div_start_ex;
    logic               div_done;
    logic               mem_req_mem;
    logic               mem_ack;
    logic               cnt_clr;

    logic               stall_pc;
    logic               stall_if_id;
    logic               stall_id_ex;
    logic               stall_ex_mem;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               flush_ex_mem;
    logic               flush_mem_wb;
    logic [CW-1:0]      stall_cnt;
    logic [CW-1:0]      flush_cnt;

    modport master (
        output rf_we_ex, rf_wd_sel_ex, rf_wa_ex, rf_ra_id, rf_re_id, npc_sel_ex,
               div_start_ex, div_done, mem_req_mem, mem_ack, cnt_clr,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  rf_we_ex, rf_wd_sel_ex, rf_wa_ex, rf_ra_id, rf_re_id, npc_sel_ex,
               div_start_ex, div_done, mem_req_mem, mem_ack, cnt_clr,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard controller: load-use bubbles, divider busy, memory wait
// and branch redirect, with saturating stall/flush cycle counters.
module hazard_ctrl_mc #(
    parameter int NRD    = 2,
    parameter int AW     = 5,
    parameter int LD_LAT = 1,
    parameter int CW     = 32
) (
    input  logic            clk,
    input  logic            rstn,
    hazard_ctrl_mc_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LU_HOLD  = 2'd1;
    localparam logic [1:0] DIV_BUSY = 2'd2;
    localparam logic [1:0] MEM_WAIT = 2'd3;
    localparam logic [2:0] LU_INIT  = 3'(LD_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ret_q, ret_d;
    logic [2:0]    lu_cnt_q, lu_cnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic [NRD-1:0] port_hit;
    logic           lu_hit;
    logic           mem_hold;
    logic [1:0]     base_state;
    logic           st_pc, st_if_id, st_id_ex, st_ex_mem;
    logic           fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            assign port_hit[gi] = bus.rf_re_id[gi] &&
                                  (bus.rf_ra_id[gi*AW +: AW] == bus.rf_wa_ex);
        end
    endgenerate

    assign lu_hit   = bus.rf_we_ex && (bus.rf_wd_sel_ex == 2'b10) &&
                      (bus.rf_wa_ex != '0) && (|port_hit);
    assign mem_hold = bus.mem_req_mem && !bus.mem_ack;
    // While waiting on memory the interrupted state is parked in ret_q.
    assign base_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        lu_cnt_d  = lu_cnt_q;
        st_pc     = 1'b0;
        st_if_id  = 1'b0;
        st_id_ex  = 1'b0;
        st_ex_mem = 1'b0;
        fl_if_id  = 1'b0;
        fl_id_ex  = 1'b0;
        fl_ex_mem = 1'b0;
        fl_mem_wb = 1'b0;
        if (mem_hold) begin
            {st_pc, st_if_id, st_id_ex, st_ex_mem} = 4'hF;
            fl_mem_wb = 1'b1;
            state_d   = MEM_WAIT;
            ret_d     = base_state;
        end else begin
            state_d = base_state;
            case (base_state)
                DIV_BUSY: begin
                    if (bus.div_done) begin
                        state_d = IDLE;
                    end else begin
                        {st_pc, st_if_id, st_id_ex, fl_ex_mem} = 4'hF;
                    end
                end
                LU_HOLD: begin
                    {st_pc, st_if_id, fl_id_ex} = 3'b111;
                    lu_cnt_d = lu_cnt_q - 3'd1;
                    if (lu_cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    // A divide that finishes in its issue cycle needs no hold.
                    if (bus.div_start_ex) begin
                        if (!bus.div_done) begin
                            {st_pc, st_if_id, st_id_ex, fl_ex_mem} = 4'hF;
                            state_d = DIV_BUSY;
                        end
                    end else if (bus.npc_sel_ex != 2'b00) begin
                        fl_if_id = 1'b1;
                        fl_id_ex = 1'b1;
                    end else if (lu_hit) begin
                        {st_pc, st_if_id, fl_id_ex} = 3'b111;
                        if (LD_LAT > 1) begin
                            state_d  = LU_HOLD;
                            lu_cnt_d = LU_INIT;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.stall_pc     = rstn & st_pc;
    assign bus.stall_if_id  = rstn & st_if_id;
    assign bus.stall_id_ex  = rstn & st_id_ex;
    assign bus.stall_ex_mem = rstn & st_ex_mem;
    assign bus.flush_if_id  = rstn & fl_if_id;
    assign bus.flush_id_ex  = rstn & fl_id_ex;
    assign bus.flush_ex_mem = rstn & fl_ex_mem;
    assign bus.flush_mem_wb = rstn & fl_mem_wb;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (st_pc && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CW'(1);
            end
            if (fl_if_id && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            lu_cnt_q    <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: doc/hazard_ctrl_mc.md
HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 The block SHALL have parameter NRD, default 2, meaning number of ID-stage register read ports (1..3).
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width.
REQ-003 The block SHALL have parameter LD_LAT, default 1, meaning load-use bubble count (1..4).
REQ-004 The block SHALL have parameter CW, default 32, meaning performance counter width.
REQ-005 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  single clock, rising edge;
 rstn  in  1  reset, asynchronous, active-low;
 rf_we_ex  in  1  EX instruction writes register file;
 rf_wd_sel_ex  in  2  EX writeback source, 2'b10 = memory (load);
 rf_wa_ex  in  AW  EX destination register;
 rf_ra_id  in  NRD*AW  ID read addresses, port k at bits [k*AW +: AW];
 rf_re_id  in  NRD  ID read-port enables;
 npc_sel_ex  in  2  EX next-PC select, nonzero = redirect;
 div_start_ex  in  1  multi-cycle divide issued in EX;
 div_done  in  1  divider result valid;
 mem_req_mem  in  1  MEM-stage memory access pending;
 mem_ack  in  1  data memory ready;
 cnt_clr  in  1  synchronous counter clear;
 stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold register;
 flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  insert bubble;
 stall_cnt  out  CW  cycles with stall_pc high;
 flush_cnt  out  CW  cycles with flush_if_id high.

Function
REQ-006 FSM states SHALL be IDLE, LU_HOLD, DIV_BUSY, MEM_WAIT; state and counters are the only storage; control outputs are combinational from state and inputs.
REQ-007 Load-use hit SHALL be: rf_we_ex, rf_wd_sel_ex==2'b10, rf_wa_ex!=0, and any port k with rf_re_id[k] and address equal to rf_wa_ex; disabled ports never hit.
REQ-008 Priority, highest first: MEM_WAIT condition, DIV_BUSY, control redirect, load-use.
REQ-009 MEM_WAIT condition (mem_req_mem && !mem_ack, any state): assert all four stalls and flush_mem_wb, all other flushes low; enter/stay MEM_WAIT; on mem_ack return to the state held before entry; LU_HOLD count frozen meanwhile.
REQ-010 div_start_ex in IDLE: assert stall_pc, stall_if_id, stall_id_ex, flush_ex_mem same cycle; enter DIV_BUSY.
REQ-011 DIV_BUSY: same outputs as REQ-010 while div_done low; cycle with div_done high: no stall, return to IDLE; div_done with div_start_ex in same cycle SHALL complete in one cycle (no state entry).
REQ-012 npc_sel_ex!=0 (IDLE): flush_if_id and flush_id_ex high, no stalls; overrides a coincident load-use hit.
REQ-013 Load-use hit in IDLE: stall_pc, stall_if_id, flush_id_ex high; if LD_LAT>1 enter LU_HOLD with down-counter = LD_LAT-1.
REQ-014 LU_HOLD: same outputs as REQ-013 regardless of EX inputs; decrement each cycle; return to IDLE after the cycle in which counter reaches 1; total bubbles = LD_LAT exactly.
REQ-015 stall_cnt SHALL increment each cycle stall_pc high, flush_cnt each cycle flush_if_id high; both saturate at all-ones, never wrap.
REQ-016 cnt_clr SHALL zero both counters next edge, overriding increment of that cycle.
REQ-017 Idle inputs SHALL yield all control outputs low.

Reset
REQ-018 rstn low SHALL immediately force state IDLE, LU_HOLD counter 0, stall_cnt=0, flush_cnt=0, saved return state IDLE.
REQ-019 While rstn low all eight control outputs SHALL be 0 regardless of inputs; reset mid-MEM_WAIT/DIV_BUSY/LU_HOLD aborts with no residual stall after release.

Verification
REQ-020 NRD=2, LD_LAT=3: load to x5 in EX, rf_ra_id port1=5, enabled -> stall_pc/stall_if_id/flush_id_ex high exactly 3 cycles, stall_cnt=3.
REQ-021 Same hit with rf_re_id=2'b00, or rf_wa_ex=0 -> no stall, stall_cnt=0.
REQ-022 Load-use hit plus npc_sel_ex=2'b01 same cycle -> flush_if_id/flush_id_ex high, stalls low, flush_cnt=1.
REQ-023 div_start_ex, div_done after 4 cycles; mem_req_mem with mem_ack low 2 cycles during cycle 2 -> 2 cycles all-stall + flush_mem_wb, then DIV_BUSY resumes, IDLE after div_done.
REQ-024 LD_LAT=4, drop rstn after 2nd bubble -> outputs 0 immediately, counters 0, no stall after release.
REQ-025 CW=4, hold stall 20 cycles -> stall_cnt stays 15; cnt_clr with stall high -> 0 next edge.
